// File: rtl/fpmult_pkg.sv
// Shared widths, constants and result types for the FPMult round/pack stage.
package fpmult_pkg;

   localparam int EXP_W = 5;
   localparam int MAN_W = 10;
   localparam int BIAS  = 15;

   localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;
   // Quiet NaN payload: only the top mantissa bit set.
   localparam logic [MAN_W-1:0] QNAN_MAN     = {1'b1, {(MAN_W-1){1'b0}}};

   // Packed IEEE result in field order {sign, exp, man}.
   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } fp_result_t;

   // Exception flags that travel with each result.
   typedef struct packed {
      logic overflow;
      logic underflow;
      logic inexact;
   } fp_flags_t;

endpackage

// File: rtl/fpmult_rne_select.sv
// Round-to-nearest-even decision and candidate selection (purely combinational).
module fpmult_rne_select
   import fpmult_pkg::*;
(
   input  logic [EXP_W+1:0] round_e_i,
   input  logic [EXP_W+1:0] round_ep_i,
   input  logic [MAN_W-1:0] round_m_i,
   input  logic [MAN_W-1:0] round_mp_i,
   input  logic [2:0]       grs_i,
   output logic [MAN_W-1:0] man_o,
   output logic [EXP_W+1:0] exp_o,
   output logic             inexact_o
);

   logic round_up;
   logic carry;

   // Ties go to the even mantissa; the carry case picks the incremented exponent.
   always_comb begin
      round_up  = grs_i[2] && (grs_i[1] || grs_i[0] || round_m_i[0]);
      carry     = round_up && (&round_m_i);
      man_o     = round_up ? round_mp_i : round_m_i;
      exp_o     = carry ? round_ep_i : round_e_i;
      inexact_o = |grs_i;
   end

endmodule

// File: rtl/fpmult_round_pack.sv
// Final FPMult stage: registered rounding (s1) then exception handling and pack (s2),
// with a valid/ready pipeline that buffers two beats under backpressure.
module fpmult_round_pack
   import fpmult_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_sign,
   input  logic [EXP_W+1:0]         in_round_e,
   input  logic [EXP_W+1:0]         in_round_ep,
   input  logic [MAN_W-1:0]         in_round_m,
   input  logic [MAN_W-1:0]         in_round_mp,
   input  logic [2:0]               in_grs,
   input  logic                     in_nan,
   input  logic                     in_inf,
   input  logic                     in_zero,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     out_result,
   output logic                     out_overflow,
   output logic                     out_underflow,
   output logic                     out_inexact
);

   // Handshake: a beat moves across a port on any cycle where valid && ready.
   // The producer holds valid and data until accepted; out_valid/out_result are
   // held stable while out_valid && !out_ready.

   localparam logic signed [EXP_W+1:0] EXP_MAX  = {2'b00, EXP_ALL_ONES};
   localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;

   // Stage 1 registers (rounded operand).
   logic                    s1_valid_q;
   logic                    s1_sign_q;
   logic signed [EXP_W+1:0] s1_exp_q;
   logic [MAN_W-1:0]        s1_man_q;
   logic                    s1_inexact_q;
   logic                    s1_nan_q;
   logic                    s1_inf_q;
   logic                    s1_zero_q;

   // Stage 2 registers (packed result).
   logic                    s2_valid_q;
   fp_result_t              s2_result_q;
   fp_flags_t               s2_flags_q;

   // Combinational next-state values.
   logic [MAN_W-1:0]        rne_man;
   logic [EXP_W+1:0]        rne_exp;
   logic                    rne_inexact;
   fp_result_t              s2_result_d;
   fp_flags_t               s2_flags_d;
   logic                    in_fire;
   logic                    s2_load;
   logic                    s1_valid_d;
   logic                    s2_valid_d;

   fpmult_rne_select u_rne (
      .round_e_i  (in_round_e),
      .round_ep_i (in_round_ep),
      .round_m_i  (in_round_m),
      .round_mp_i (in_round_mp),
      .grs_i      (in_grs),
      .man_o      (rne_man),
      .exp_o      (rne_exp),
      .inexact_o  (rne_inexact)
   );

   // Flow control: s1 frees up whenever it can move into s2, so a full pipe
   // still accepts a new beat on the cycle the consumer takes one.
   always_comb begin
      in_ready   = !s1_valid_q || !s2_valid_q || out_ready;
      in_fire    = in_valid && in_ready;
      s2_load    = s1_valid_q && (!s2_valid_q || out_ready);
      s1_valid_d = s1_valid_q;
      if (in_fire) begin
         s1_valid_d = 1'b1;
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end
      s2_valid_d = s2_valid_q;
      if (s2_load) begin
         s2_valid_d = 1'b1;
      end else if (out_ready) begin
         s2_valid_d = 1'b0;
      end
   end

   // Exception priority: NaN, inf, zero, exponent overflow, underflow, normal.
   always_comb begin
      s2_result_d.sign = s1_sign_q;
      s2_result_d.exp  = s1_exp_q[EXP_W-1:0];
      s2_result_d.man  = s1_man_q;
      s2_flags_d       = '{overflow: 1'b0, underflow: 1'b0, inexact: s1_inexact_q};
      if (s1_nan_q) begin
         s2_result_d = '{sign: 1'b0, exp: EXP_ALL_ONES, man: QNAN_MAN};
         s2_flags_d  = '0;
      end else if (s1_inf_q) begin
         s2_result_d = '{sign: s1_sign_q, exp: EXP_ALL_ONES, man: '0};
         s2_flags_d  = '0;
      end else if (s1_zero_q) begin
         s2_result_d = '{sign: s1_sign_q, exp: '0, man: '0};
         s2_flags_d  = '0;
      end else if (s1_exp_q >= EXP_MAX) begin
         s2_result_d = '{sign: s1_sign_q, exp: EXP_ALL_ONES, man: '0};
         s2_flags_d  = '{overflow: 1'b1, underflow: 1'b0, inexact: 1'b1};
      end else if (s1_exp_q <= EXP_ZERO) begin
         // Denormals are flushed to signed zero.
         s2_result_d = '{sign: s1_sign_q, exp: '0, man: '0};
         s2_flags_d  = '{overflow: 1'b0, underflow: 1'b1, inexact: 1'b1};
      end
   end

   // Stage 1: capture the rounded candidate and special flags on input transfer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid_q   <= 1'b0;
         s1_sign_q    <= 1'b0;
         s1_exp_q     <= '0;
         s1_man_q     <= '0;
         s1_inexact_q <= 1'b0;
         s1_nan_q     <= 1'b0;
         s1_inf_q     <= 1'b0;
         s1_zero_q    <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (in_fire) begin
            s1_sign_q    <= in_sign;
            s1_exp_q     <= $signed(rne_exp);
            s1_man_q     <= rne_man;
            s1_inexact_q <= rne_inexact;
            s1_nan_q     <= in_nan;
            s1_inf_q     <= in_inf;
            s1_zero_q    <= in_zero;
         end
      end
   end

   // Stage 2: capture the packed result when s1 advances; held while stalled.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s2_valid_q  <= 1'b0;
         s2_result_q <= '0;
         s2_flags_q  <= '0;
      end else begin
         s2_valid_q <= s2_valid_d;
         if (s2_load) begin
            s2_result_q <= s2_result_d;
            s2_flags_q  <= s2_flags_d;
         end
      end
   end

   assign out_valid     = s2_valid_q;
   assign out_result    = s2_result_q;
   assign out_overflow  = s2_flags_q.overflow;
   assign out_underflow = s2_flags_q.underflow;
   assign out_inexact   = s2_flags_q.inexact;

endmodule

// File: tb/tb_fpmult_round_pack.sv
// Bench for fpmult_round_pack: directed vector table, backpressure, random
// streaming against a reference model, and reset with beats in flight.
`timescale 1ns/1ps
module tb_fpmult_round_pack;
   import fpmult_pkg::*;

   localparam int W = 19;   // {result[15:0], overflow, underflow, inexact}

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, in_sign, in_nan, in_inf, in_zero;
   logic [6:0]  in_round_e, in_round_ep;
   logic [9:0]  in_round_m, in_round_mp;
   logic [2:0]  in_grs;
   logic        out_valid, out_ready, out_overflow, out_underflow, out_inexact;
   logic [15:0] out_result;

   fpmult_round_pack dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_sign      (in_sign),
      .in_round_e   (in_round_e),
      .in_round_ep  (in_round_ep),
      .in_round_m   (in_round_m),
      .in_round_mp  (in_round_mp),
      .in_grs       (in_grs),
      .in_nan       (in_nan),
      .in_inf       (in_inf),
      .in_zero      (in_zero),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_overflow (out_overflow),
      .out_underflow(out_underflow),
      .out_inexact  (out_inexact)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int out_count = 0;
   logic [W-1:0] exp_q[$];

   typedef struct {
      logic s;
      int   e;
      int   m;
      int   grs;
      logic nan;
      logic inf;
      logic zero;
   } beat_t;

   typedef struct {
      beat_t       b;
      logic [15:0] res;
      logic        ovf;
      logic        unf;
      logic        inx;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
      end
   endtask

   // Reference model: works on the real significand value 1.m and the GRS tail
   // as a fraction of one ulp, not on the candidate pairs.
   function automatic logic [W-1:0] model(logic s, int e, int m, int grs,
                                          logic nan, logic inf, logic zero);
      int sig;
      int ee;
      logic [15:0] r;
      if (nan)  return {16'h7E00, 3'b000};
      if (inf)  return {s, 5'h1F, 10'h000, 3'b000};
      if (zero) return {s, 15'h0000, 3'b000};
      sig = 1024 + m;
      if (grs > 4 || (grs == 4 && (m % 2) == 1)) sig = sig + 1;
      ee = e;
      if (sig == 2048) begin
         ee  = ee + 1;
         sig = 1024;
      end
      if (ee >= 31) return {s, 5'h1F, 10'h000, 3'b101};
      if (ee <= 0)  return {s, 15'h0000, 3'b011};
      r = {s, 5'(ee), 10'(sig - 1024)};
      return {r, 2'b00, (grs != 0)};
   endfunction

   function automatic beat_t mk_beat(logic s, int e, int m, int grs,
                                     logic nan, logic inf, logic zero);
      beat_t b;
      b.s = s; b.e = e; b.m = m; b.grs = grs; b.nan = nan; b.inf = inf; b.zero = zero;
      return b;
   endfunction

   function automatic vec_t mk_vec(beat_t b, logic [15:0] res, logic ovf, logic unf, logic inx);
      vec_t v;
      v.b = b; v.res = res; v.ovf = ovf; v.unf = unf; v.inx = inx;
      return v;
   endfunction

   function automatic beat_t rand_beat();
      beat_t b;
      int sel;
      b.s   = 1'($urandom_range(0, 1));
      b.e   = int'($urandom_range(0, 50)) - 10;
      b.m   = int'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) b.m = 1023;
      b.grs = int'($urandom_range(0, 7));
      sel   = int'($urandom_range(0, 15));
      b.nan  = (sel == 0) || (sel == 3);
      b.inf  = (sel == 1) || (sel == 3);
      b.zero = (sel == 2);
      if (b.inf || b.zero) b.grs = 0;
      return b;
   endfunction

   // ---------------- driver tasks ----------------
   // Called just after a rising edge; returns just after the edge that accepted the beat.
   task automatic drive_beat(input beat_t b);
      int k;
      in_valid    = 1'b1;
      in_sign     = b.s;
      in_round_e  = 7'(b.e);
      in_round_ep = 7'(b.e + 1);
      in_round_m  = 10'(b.m);
      in_round_mp = 10'(b.m + 1);
      in_grs      = 3'(b.grs);
      in_nan      = b.nan;
      in_inf      = b.inf;
      in_zero     = b.zero;
      k = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         k++;
         if (k > 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drive_timeout: in_ready stuck at 0, required 1");
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic scramble_idle_inputs();
      in_valid    = 1'b0;
      in_sign     = 1'($urandom);
      in_round_e  = 7'($urandom);
      in_round_ep = 7'($urandom);
      in_round_m  = 10'($urandom);
      in_round_mp = 10'($urandom);
      in_grs      = 3'($urandom);
      in_nan      = 1'($urandom);
      in_inf      = 1'($urandom);
      in_zero     = 1'($urandom);
   endtask

   task automatic wait_drain(input string name);
      for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
         @(posedge clk);
         #1;
      end
      check(name, exp_q.size(), 0);
   endtask

   // ---------------- scoreboard / monitor ----------------
   logic        prev_stall = 1'b0;
   logic [15:0] prev_result = '0;
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (!rst) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_result", out_result, prev_result);
         end
         if (out_valid && out_ready) begin
            out_count++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_output: got %0h expected no output", out_result);
            end else begin
               e = exp_q.pop_front();
               check("stream", {out_result, out_overflow, out_underflow, out_inexact}, e);
            end
         end
         if (in_valid && in_ready)
            exp_q.push_back(model(in_sign, int'($signed(in_round_e)), int'(in_round_m),
                                  int'(in_grs), in_nan, in_inf, in_zero));
         prev_stall  = out_valid && !out_ready;
         prev_result = out_result;
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   vec_t vt[14];
   int   cnt0;
   logic stream_done;
   beat_t bp[4];
   logic [W-1:0] m0;

   initial begin
      vt[0]  = mk_vec(mk_beat(0, 15, 10'h3FF, 3'b100, 0, 0, 0), 16'h4000, 0, 0, 1);
      vt[1]  = mk_vec(mk_beat(0, 15, 10'h002, 3'b100, 0, 0, 0), 16'h3C02, 0, 0, 1);
      vt[2]  = mk_vec(mk_beat(0, 15, 10'h003, 3'b100, 0, 0, 0), 16'h3C04, 0, 0, 1);
      vt[3]  = mk_vec(mk_beat(1, 31, 10'h000, 3'b000, 0, 0, 0), 16'hFC00, 1, 0, 1);
      vt[4]  = mk_vec(mk_beat(1, 0,  10'h000, 3'b000, 0, 0, 0), 16'h8000, 0, 1, 1);
      vt[5]  = mk_vec(mk_beat(0, -3, 10'h123, 3'b010, 0, 0, 0), 16'h0000, 0, 1, 1);
      vt[6]  = mk_vec(mk_beat(1, 15, 10'h155, 3'b111, 1, 0, 0), 16'h7E00, 0, 0, 0);
      vt[7]  = mk_vec(mk_beat(1, 15, 10'h000, 3'b000, 0, 1, 0), 16'hFC00, 0, 0, 0);
      vt[8]  = mk_vec(mk_beat(1, 15, 10'h000, 3'b000, 0, 0, 1), 16'h8000, 0, 0, 0);
      vt[9]  = mk_vec(mk_beat(0, 30, 10'h3FF, 3'b111, 0, 0, 0), 16'h7C00, 1, 0, 1);
      vt[10] = mk_vec(mk_beat(0, 1,  10'h005, 3'b011, 0, 0, 0), 16'h0405, 0, 0, 1);
      vt[11] = mk_vec(mk_beat(0, 20, 10'h010, 3'b000, 0, 0, 0), 16'h5010, 0, 0, 0);
      vt[12] = mk_vec(mk_beat(0, 15, 10'h001, 3'b101, 0, 0, 0), 16'h3C02, 0, 0, 1);
      vt[13] = mk_vec(mk_beat(0, 15, 10'h000, 3'b000, 1, 1, 0), 16'h7E00, 0, 0, 0);

      // reset
      scramble_idle_inputs();
      out_ready = 1'b1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_result", out_result, 0);
      check("rst_flags", {out_overflow, out_underflow, out_inexact}, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // directed vectors, each run alone through an empty pipe
      for (int i = 0; i < 14; i++) begin
         drive_beat(vt[i].b);
         scramble_idle_inputs();
         @(negedge clk);
         check($sformatf("vec%0d_latency1", i), out_valid, 0);
         @(posedge clk);
         @(negedge clk);
         check($sformatf("vec%0d_valid", i), out_valid, 1);
         check($sformatf("vec%0d_result", i), out_result, vt[i].res);
         check($sformatf("vec%0d_flags", i), {out_overflow, out_underflow, out_inexact},
               {vt[i].ovf, vt[i].unf, vt[i].inx});
         @(posedge clk);
         #1;
      end
      wait_drain("vec_drain");

      // backpressure: 4 beats while out_ready is low for 5 cycles
      for (int i = 0; i < 4; i++) bp[i] = rand_beat();
      bp[0] = mk_beat(0, 15, 10'h002, 3'b100, 0, 0, 0);
      m0 = model(bp[0].s, bp[0].e, bp[0].m, bp[0].grs, bp[0].nan, bp[0].inf, bp[0].zero);
      cnt0 = out_count;
      fork
         begin
            out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
         begin
            drive_beat(bp[0]);
            drive_beat(bp[1]);
            #2;
            check("bp_in_ready_low", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_head_result", out_result, m0[18:3]);
            drive_beat(bp[2]);
            drive_beat(bp[3]);
         end
      join
      wait_drain("bp_drain");
      check("bp_count", out_count - cnt0, 4);

      // random streaming with random backpressure
      cnt0 = out_count;
      stream_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               repeat ($urandom_range(0, 2)) begin
                  scramble_idle_inputs();
                  @(posedge clk);
                  #1;
               end
               drive_beat(rand_beat());
            end
            scramble_idle_inputs();
            stream_done = 1'b1;
         end
         begin
            while (!stream_done) begin
               out_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk);
               #1;
            end
         end
      join
      out_ready = 1'b1;
      wait_drain("stream_drain");
      check("stream_count", out_count - cnt0, 100);

      // reset with two beats buffered
      out_ready = 1'b0;
      drive_beat(rand_beat());
      drive_beat(rand_beat());
      scramble_idle_inputs();
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_result", out_result, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_flags", {out_overflow, out_underflow, out_inexact}, 0);
      @(posedge clk);
      #1;
      cnt0 = out_count;
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("midrst_no_stale", out_count - cnt0, 0);
      drive_beat(vt[1].b);
      scramble_idle_inputs();
      wait_drain("midrst_recover");
      check("midrst_recover_count", out_count - cnt0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fpmult_round_pack.md
Name: fpmult_round_pack

Overview:
- Final stage of the FPMult pipeline. It consumes the candidate pairs produced by normalization: exponent / exponent+1 and mantissa / mantissa+1.
- It takes the round-to-nearest-even decision, selects a candidate pair, handles overflow, underflow and special operands, and packs the IEEE result.
- Two-stage registered pipeline with valid/ready handshake on both sides, so it sits between the normalize logic and the result consumer under backpressure.

Parameters:
- EXP_W, 5, exponent field width.
- MAN_W, 10, stored mantissa width (hidden bit excluded).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_sign  in  1  result sign.
- in_round_e  in  EXP_W+2  signed biased exponent if no mantissa carry.
- in_round_ep  in  EXP_W+2  signed biased exponent if rounding carries; always in_round_e+1.
- in_round_m  in  MAN_W  truncated mantissa.
- in_round_mp  in  MAN_W  in_round_m+1, wraps modulo 2^MAN_W.
- in_grs  in  3  guard, round, sticky bits.
- in_nan  in  1  operand NaN or inf*0.
- in_inf  in  1  operand infinite (not NaN).
- in_zero  in  1  operand zero (not NaN/inf).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_result  out  1+EXP_W+MAN_W  packed {sign, exp, man}.
- out_overflow  out  1  result forced to infinity by exponent overflow.
- out_underflow  out  1  result flushed to zero.
- out_inexact  out  1  any of GRS nonzero, or overflow/underflow occurred.

Behaviour:
- Reset (rst==0 at a clk edge): s1_valid=0, s2_valid=0, out_result=0, all flags 0. In-flight beats are dropped, with no partial output. in_ready=1 from the first cycle after reset releases.
- Handshake:
  - A transfer occurs on a cycle where valid&&ready.
  - out_valid and out_result stay stable while out_valid&&!out_ready.
  - in_ready = !s1_valid || !s2_valid || out_ready, combinational.
- Pipeline rules:
  - s2 loads from s1 when s1_valid && (!s2_valid || out_ready).
  - s1 loads from the input on input transfer.
  - Latency is 2 cycles from input transfer to out_valid when unstalled. Throughput is 1 beat/cycle. Order is preserved.
  - Two beats are buffered when out_ready is low.
- Stage 1 (rounding):
  - round_up = G && (R || S || in_round_m[0]), i.e. RNE ties to even.
  - carry = round_up && (in_round_m == all ones).
  - man = round_up ? in_round_mp : in_round_m.
  - exp = carry ? in_round_ep : in_round_e.
  - inexact = |GRS.
  - Register sign, man, exp, inexact and the special flags.
- Stage 2 (exceptions and pack), priority order:
  - nan: result = {0, all ones, 1<<(MAN_W-1)}, i.e. quiet NaN 16'h7E00. All flags 0.
  - inf: {sign, all ones, 0}.
  - zero: {sign, 0, 0}.
  - exp >= 2^EXP_W-1 (signed compare): {sign, all ones, 0}; overflow=1, inexact=1.
  - exp <= 0: {sign, 0, 0}. Denormals are flushed. underflow=1, inexact=1.
  - otherwise: {sign, exp[EXP_W-1:0], man}; inexact is passed through from stage 1.
- Simultaneous in and out transfer while both stages are full: the stages shift and the new beat enters s1 in the same cycle; no bubble.
- Input fields are ignored when in_valid=0.

Decomposition:
- Shared package fpmult_pkg:
  - EXP_W, MAN_W, BIAS=15.
  - Constants QNAN_MAN, EXP_ALL_ONES.
  - A packed-result struct type.
- One natural sub-module: fpmult_rne_select, purely combinational stage-1 logic producing round_up, carry, man, exp and inexact. Pipeline, control and packing stay in the top module.

Test Plan:
- Carry: in_round_e=15, in_round_ep=16, in_round_m=10'h3FF, in_round_mp=10'h000, grs=3'b100, sign=0 -> out_result=16'h4000, inexact=1, out_valid 2 cycles after accept.
- Tie-to-even down: e=15, m=10'h002, mp=10'h003, grs=3'b100 -> 16'h3C02, inexact=1. Same with m=10'h003 -> 16'h3C04.
- Overflow/underflow/specials:
  - sign=1, e=31 -> 16'hFC00, overflow=1.
  - sign=1, e=0 -> 16'h8000, underflow=1.
  - e=-3 -> 16'h0000, underflow=1.
  - in_nan=1 -> 16'h7E00.
  - in_inf=1, sign=1 -> 16'hFC00, overflow=0.
- Backpressure: send 4 back-to-back beats with out_ready=0 for 5 cycles.
  - Expected: in_ready deasserts after the 2nd accept, and out_result stays held.
  - Releasing out_ready drains all 4 in order with no loss or duplication.
- Streaming: 100 random beats with random out_ready -> results match the reference model in order.
- Reset mid-flight: assert rst low with 2 beats buffered -> next cycle out_valid=0, out_result=0, in_ready=1, and no stale beat ever emerges afterwards.
